// File: rtl/param_timer_bank.sv
// Programmable time-parameter store with a selectable, optionally doubled
// read-out and an integrated countdown timer paced by a prescaled tick.
module param_timer_bank #(
    parameter int                          NUM_PARAMS = 4,
    parameter int                          VAL_W      = 4,
    parameter int                          OUT_W      = VAL_W + 1,
    parameter int                          TICK_DIV   = 10,
    parameter logic [NUM_PARAMS*VAL_W-1:0] DEFAULTS   = {4'd15, 4'd10, 4'd8, 4'd6}
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [$clog2(NUM_PARAMS)-1:0] time_param_sel,
    input  logic [VAL_W-1:0]              time_value,
    input  logic                          reprogram,
    input  logic [$clog2(NUM_PARAMS)-1:0] interval,
    input  logic                          double_mode,
    input  logic                          start,
    output logic [OUT_W-1:0]              value,
    output logic [OUT_W-1:0]              remaining,
    output logic                          busy,
    output logic                          expired,
    output logic                          tick
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    logic [VAL_W-1:0] param_q [NUM_PARAMS];
    logic [VAL_W-1:0] param_d [NUM_PARAMS];

    logic [VAL_W-1:0] selVal;
    logic [OUT_W-1:0] selExt;

    state_t           state_q,     state_d;
    logic [PRE_W-1:0] preCount_q,  preCount_d;
    logic [OUT_W-1:0] remaining_q, remaining_d;
    logic             expired_q,   expired_d;
    logic             tick_q,      tick_d;

    // Parameter store next state: a write of zero restores that entry's default,
    // and a select that matches no entry leaves the whole store untouched.
    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            param_d[i] = param_q[i];
            if (reprogram && (int'(time_param_sel) == i)) begin
                if (time_value == '0) begin
                    param_d[i] = DEFAULTS[i*VAL_W +: VAL_W];
                end else begin
                    param_d[i] = time_value;
                end
            end
        end
    end

    // Parameter store registers, loaded with the packed defaults on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
            end
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= param_d[i];
            end
        end
    end

    // Read-out mux: an out-of-range interval reads as zero; doubling is a
    // left shift into the extra output bit so it can never overflow.
    always_comb begin
        selVal = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (int'(interval) == i) begin
                selVal = param_q[i];
            end
        end
        selExt = OUT_W'(selVal);
        if (double_mode) begin
            value = selExt << 1;
        end else begin
            value = selExt;
        end
    end

    // Timer next state: reprogram aborts everything, start (re)loads from the
    // current read-out, otherwise RUN counts prescaler wraps down to zero.
    always_comb begin
        state_d     = state_q;
        preCount_d  = preCount_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        tick_d      = 1'b0;

        if (reprogram) begin
            state_d     = ST_IDLE;
            preCount_d  = '0;
            remaining_d = '0;
        end else if (start) begin
            preCount_d  = '0;
            remaining_d = value;
            if (value == '0) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end else begin
                state_d   = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (preCount_q == PRE_LAST) begin
                        preCount_d  = '0;
                        tick_d      = 1'b1;
                        remaining_d = remaining_q - OUT_W'(1);
                        if (remaining_q == OUT_W'(1)) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
                    end else begin
                        preCount_d = preCount_q + PRE_W'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d     = ST_IDLE;
                    preCount_d  = '0;
                    remaining_d = '0;
                end
            endcase
        end
    end

    // Timer state registers; the pulse outputs are registered so they are
    // glitch-free and line up with the remaining count they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            preCount_q  <= '0;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            preCount_q  <= preCount_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            tick_q      <= tick_d;
        end
    end

    assign remaining = remaining_q;
    assign busy      = (state_q == ST_RUN);
    assign expired   = expired_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_param_timer_bank.sv
// Bench for param_timer_bank: two instances (default build and a 3-entry,
// fast-tick build) checked every cycle against a behavioural model, plus
// directed scenarios with hand-computed expectations.
module tb_param_timer_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       reprogram;
    logic [1:0] interval;
    logic       double_mode;
    logic       start;

    logic [4:0] valueA, remA, valueB, remB;
    logic       busyA, expiredA, tickA, busyB, expiredB, tickB;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  checkEn     = 1'b0;

    // Behavioural model state, one slot per instance.
    int  numP[2]      = '{4, 3};
    int  tdiv[2]      = '{10, 3};
    int  defv[2][4]   = '{'{6, 8, 10, 15}, '{5, 7, 9, 0}};
    int  prm[2][4];
    bit  running[2];
    int  startEdge[2];
    int  loadVal[2];
    int  expRem[2];
    bit  expBusy[2];
    bit  expTick[2];
    bit  expExp[2];
    int  edgeCnt;

    always #5 clock = ~clock;

    param_timer_bank uA (
        .clock(clock), .reset(reset), .time_param_sel(time_param_sel),
        .time_value(time_value), .reprogram(reprogram), .interval(interval),
        .double_mode(double_mode), .start(start), .value(valueA),
        .remaining(remA), .busy(busyA), .expired(expiredA), .tick(tickA)
    );

    param_timer_bank #(
        .NUM_PARAMS(3),
        .TICK_DIV(3),
        .DEFAULTS({4'd9, 4'd7, 4'd5})
    ) uB (
        .clock(clock), .reset(reset), .time_param_sel(time_param_sel),
        .time_value(time_value), .reprogram(reprogram), .interval(interval),
        .double_mode(double_mode), .start(start), .value(valueB),
        .remaining(remB), .busy(busyB), .expired(expiredB), .tick(tickB)
    );

    function automatic int modelValue(input int u, input int sel, input bit dbl);
        if (sel >= numP[u]) return 0;
        return dbl ? prm[u][sel] * 2 : prm[u][sel];
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // The timer is modelled as elapsed edges since the start edge:
    // remaining = load - elapsed/TICK_DIV, tick on every multiple of TICK_DIV.
    task automatic modelUpdate();
        int v;
        int k;
        if (!reset) begin
            edgeCnt = 0;
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 4; i++) prm[u][i] = defv[u][i];
                running[u] = 0; expRem[u] = 0; expBusy[u] = 0;
                expTick[u] = 0; expExp[u] = 0;
            end
        end else begin
            edgeCnt++;
            for (int u = 0; u < 2; u++) begin
                v = modelValue(u, int'(interval), double_mode);
                expTick[u] = 0;
                expExp[u]  = 0;
                if (reprogram) begin
                    if (int'(time_param_sel) < numP[u])
                        prm[u][time_param_sel] = (time_value == 0) ?
                            defv[u][time_param_sel] : int'(time_value);
                    running[u] = 0; expRem[u] = 0; expBusy[u] = 0;
                end else if (start) begin
                    if (v == 0) begin
                        running[u] = 0; expRem[u] = 0; expBusy[u] = 0; expExp[u] = 1;
                    end else begin
                        running[u] = 1; startEdge[u] = edgeCnt; loadVal[u] = v;
                        expRem[u] = v; expBusy[u] = 1;
                    end
                end else if (running[u]) begin
                    k = edgeCnt - startEdge[u];
                    expRem[u]  = loadVal[u] - k / tdiv[u];
                    expTick[u] = (k % tdiv[u] == 0);
                    if (expRem[u] == 0) begin
                        running[u] = 0; expBusy[u] = 0; expExp[u] = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            modelUpdate();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (checkEn) begin
                checkOutput("valueA",   int'(valueA),   modelValue(0, int'(interval), double_mode));
                checkOutput("remA",     int'(remA),     expRem[0]);
                checkOutput("busyA",    int'(busyA),    int'(expBusy[0]));
                checkOutput("expiredA", int'(expiredA), int'(expExp[0]));
                checkOutput("tickA",    int'(tickA),    int'(expTick[0]));
                checkOutput("valueB",   int'(valueB),   modelValue(1, int'(interval), double_mode));
                checkOutput("remB",     int'(remB),     expRem[1]);
                checkOutput("busyB",    int'(busyB),    int'(expBusy[1]));
                checkOutput("expiredB", int'(expiredB), int'(expExp[1]));
                checkOutput("tickB",    int'(tickB),    int'(expTick[1]));
            end
        end
    end

    task automatic applyStimulus(input bit rp, input int sel, input int tv,
                                 input int iv, input bit dm, input bit st);
        @(negedge clock);
        #1;
        reprogram      = rp;
        time_param_sel = 2'(sel);
        time_value     = 4'(tv);
        interval       = 2'(iv);
        double_mode    = dm;
        start          = st;
    endtask

    // Wait (bounded) for expiredA and return edges elapsed since t0 plus ticks seen.
    task automatic waitExpiredA(input time t0, input int budget,
                                output int edges, output int ticks);
        bit found;
        found = 0;
        ticks = 0;
        edges = -1;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clock);
            if (tickA) ticks++;
            if (expiredA) begin
                found = 1;
                edges = int'(($time - t0 - 5) / 10);
            end
        end
    endtask

    int  lits[4] = '{6, 8, 10, 15};
    time t0;
    int  edges, ticks;
    bit  hit;

    initial begin
        reset = 1'b0; reprogram = 0; time_param_sel = 0; time_value = 0;
        interval = 0; double_mode = 0; start = 0;
        @(posedge clock);
        #1 checkEn = 1'b1;
        repeat (2) @(negedge clock);
        #3 reset = 1'b1;

        // Defaults after reset release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, i, 0, 0);
            #1;
            checkOutput("rstValue", int'(valueA), lits[i]);
        end
        checkOutput("rstBusy", int'(busyA), 0);
        checkOutput("rstRem",  int'(remA), 0);
        checkOutput("rstExp",  int'(expiredA), 0);

        // Write, double, restore default.
        applyStimulus(1, 1, 5, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        #1 checkOutput("write5", int'(valueA), 5);
        applyStimulus(0, 0, 0, 1, 1, 0);
        #1 checkOutput("double5", int'(valueA), 10);
        applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        #1 checkOutput("restore8", int'(valueA), 8);

        // Basic countdown from 6.
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(posedge clock);
        t0 = $time;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 checkOutput("loadRem6", int'(remA), 6);
        waitExpiredA(t0, 200, edges, ticks);
        checkOutput("latency60", edges, 60);
        checkOutput("ticks6", ticks, 6);
        @(negedge clock);
        checkOutput("busyAfter", int'(busyA), 0);

        // Restart at remaining=3 with interval 2 (10).
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clock);
            if (remA == 5'd3) hit = 1;
        end
        checkOutput("reachRem3", int'(hit), 1);
        applyStimulus(0, 0, 0, 2, 0, 1);
        @(posedge clock);
        t0 = $time;
        applyStimulus(0, 0, 0, 2, 0, 0);
        #1 checkOutput("reloadRem10", int'(remA), 10);
        waitExpiredA(t0, 300, edges, ticks);
        checkOutput("latency100", edges, 100);

        // Reprogram during RUN aborts and writes.
        applyStimulus(0, 0, 0, 1, 0, 1);
        repeat (15) @(negedge clock);
        applyStimulus(1, 2, 12, 2, 0, 0);
        applyStimulus(0, 0, 0, 2, 0, 0);
        #1;
        checkOutput("abortBusy",  int'(busyA), 0);
        checkOutput("abortRem",   int'(remA), 0);
        checkOutput("abortValue", int'(valueA), 12);
        repeat (100) @(negedge clock);

        // Reprogram and start together: reprogram wins.
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (5) @(negedge clock);
        applyStimulus(1, 0, 3, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rpStBusy",  int'(busyA), 0);
        checkOutput("rpStRem",   int'(remA), 0);
        checkOutput("rpStValue", int'(valueA), 3);

        // Zero load on the 3-entry build (interval 3 out of range).
        applyStimulus(0, 0, 0, 3, 0, 1);
        applyStimulus(0, 0, 0, 3, 0, 0);
        #1;
        checkOutput("zeroExpB",  int'(expiredB), 1);
        checkOutput("zeroBusyB", int'(busyB), 0);

        // Asynchronous reset mid-count.
        repeat (20) @(negedge clock);
        #3 reset = 1'b0;
        #1;
        checkOutput("asyncBusy",  int'(busyA), 0);
        checkOutput("asyncRem",   int'(remA), 0);
        checkOutput("asyncValue", int'(valueA), 15);
        @(negedge clock);
        #3 reset = 1'b1;

        // Randomised phase.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                @(negedge clock);
                #3 reset = 1'b0;
                @(negedge clock);
                #3 reset = 1'b1;
            end
            applyStimulus($urandom_range(0, 39) == 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
